// File: rtl/mole_scheduler_if.sv
// Bundles the game-facing signals of the mole scheduler: button/start inputs
// from the debouncers and the display-side status outputs.
interface mole_scheduler_if #(
  parameter int NHOLES = 4
);
  logic              start;
  logic [NHOLES-1:0] btn;
  logic [NHOLES-1:0] mole;
  logic [7:0]        score;
  logic [1:0]        lives;
  logic [2:0]        level;
  logic              playing;
  logic              game_over;
  logic              tick;

  // Stimulus side: drives start/buttons, observes game state
  modport master (
    output start, btn,
    input  mole, score, lives, level, playing, game_over, tick
  );

  // Scheduler side
  modport slave (
    input  start, btn,
    output mole, score, lives, level, playing, game_over, tick
  );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: chooses the lit hole from an LFSR, times the
// visible window with a level-dependent tick, judges hits/misses and tracks
// score, lives and level. All outputs are registered.
module mole_scheduler #(
  parameter int          NHOLES         = 4,
  parameter int          TICK_BASE      = 37500000,
  parameter int          TICK_STEP      = 3750000,
  parameter int          MIN_TICKS      = 7500000,
  parameter int          HITS_PER_LEVEL = 5,
  parameter int          LIVES          = 3,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic             clk1s,
  input  logic             rst,
  mole_scheduler_if.slave  bus
);

  localparam int HW = (NHOLES > 1) ? $clog2(NHOLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PICK, S_SHOW, S_GAP, S_OVER} state_t;

  state_t            r_state;
  logic [15:0]       r_lfsr;
  logic [31:0]       r_cnt;
  logic [HW-1:0]     r_prev;
  logic [7:0]        r_hits;
  logic [7:0]        r_score;
  logic [1:0]        r_lives;
  logic [2:0]        r_level;
  logic [NHOLES-1:0] r_mole;
  logic              r_playing;
  logic              r_game_over;
  logic              r_tick;
  logic              r_start_d;
  logic              r_start_e;
  logic [NHOLES-1:0] r_btn_d;
  logic [NHOLES-1:0] r_btn_e;

  logic [31:0]       w_dec;
  logic [31:0]       w_period;
  logic              w_tick;
  logic [15:0]       w_lfsr_next;
  logic [7:0]        w_h0;
  logic [7:0]        w_hsel;
  logic [NHOLES-1:0] w_onehot;

  // Window length shrinks by TICK_STEP per level, never below MIN_TICKS;
  // the compare avoids unsigned underflow at high levels.
  always_comb begin
    w_dec = 32'(r_level) * 32'(TICK_STEP);
    if ((32'(TICK_BASE) > w_dec) && ((32'(TICK_BASE) - w_dec) > 32'(MIN_TICKS)))
      w_period = 32'(TICK_BASE) - w_dec;
    else
      w_period = 32'(MIN_TICKS);
    w_tick = (r_cnt == (w_period - 32'd1));
  end

  // Galois LFSR x^16+x^14+x^13+x^11+1 and next-hole selection (never repeats the last hole)
  always_comb begin
    w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    w_h0        = r_lfsr[7:0] % 8'(NHOLES);
    if (w_h0 == 8'(r_prev))
      w_hsel = ((w_h0 + 8'd1) == 8'(NHOLES)) ? 8'd0 : (w_h0 + 8'd1);
    else
      w_hsel = w_h0;
    w_onehot = '0;
    w_onehot[w_hsel[HW-1:0]] = 1'b1;
  end

  // Game FSM with edge detection, window counter and registered outputs
  always_ff @(posedge clk1s or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_hits      <= '0;
      r_score     <= '0;
      r_lives     <= '0;
      r_level     <= '0;
      r_mole      <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
      r_tick      <= 1'b0;
      r_start_d   <= 1'b0;
      r_start_e   <= 1'b0;
      r_btn_d     <= '0;
      r_btn_e     <= '0;
    end else begin
      r_lfsr    <= w_lfsr_next;
      r_start_d <= bus.start;
      r_start_e <= bus.start & ~r_start_d;
      r_btn_d   <= bus.btn;
      r_btn_e   <= bus.btn & ~r_btn_d;
      r_tick    <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          r_mole <= '0;
          r_cnt  <= '0;
          if (r_start_e) begin
            r_state     <= S_PICK;
            r_score     <= '0;
            r_lives     <= 2'(LIVES);
            r_level     <= '0;
            r_hits      <= '0;
            r_playing   <= 1'b1;
            r_game_over <= 1'b0;
          end
        end
        S_PICK: begin
          r_prev  <= w_hsel[HW-1:0];
          r_mole  <= w_onehot;
          r_cnt   <= '0;
          r_state <= S_SHOW;
        end
        S_SHOW: begin
          if (r_btn_e[r_prev]) begin
            // A press on the lit hole wins over wrong presses and over the tick
            r_tick  <= w_tick;
            r_mole  <= '0;
            r_cnt   <= '0;
            r_state <= S_GAP;
            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            if ((r_hits + 8'd1) >= 8'(HITS_PER_LEVEL)) begin
              r_hits <= '0;
              if (r_level != 3'd7) r_level <= r_level + 3'd1;
            end else begin
              r_hits <= r_hits + 8'd1;
            end
          end else if ((|r_btn_e) || w_tick) begin
            r_tick  <= w_tick;
            r_mole  <= '0;
            r_cnt   <= '0;
            r_lives <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_state     <= S_OVER;
              r_playing   <= 1'b0;
              r_game_over <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (w_tick) begin
            r_tick  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_PICK;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_mole  <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.mole      = r_mole;
  assign bus.score     = r_score;
  assign bus.lives     = r_lives;
  assign bus.level     = r_level;
  assign bus.playing   = r_playing;
  assign bus.game_over = r_game_over;
  assign bus.tick      = r_tick;

endmodule

// File: tb/tb_mole_scheduler.sv
// Directed bench for mole_scheduler with short windows (base 10, step 2,
// floor 4, two hits per level, three lives, four holes).
module tb_mole_scheduler;

  logic clk1s = 1'b0;
  logic rst   = 1'b1;

  always #5 clk1s = ~clk1s;

  mole_scheduler_if #(.NHOLES(4)) bus();

  mole_scheduler #(
    .NHOLES(4), .TICK_BASE(10), .TICK_STEP(2), .MIN_TICKS(4),
    .HITS_PER_LEVEL(2), .LIVES(3), .SEED(16'hACE1)
  ) dut (
    .clk1s(clk1s),
    .rst(rst),
    .bus(bus.slave)
  );

  localparam int K_LIT  = 0;  // press the lit hole
  localparam int K_BOTH = 1;  // press lit hole plus a wrong one
  localparam int K_NONE = 2;  // no press, window expires
  localparam int K_TICK = 3;  // press timed to land on the tick cycle

  typedef struct {
    int kind;
    int score;
    int level;
    int lives;
    int on;    // expected SHOW length (K_NONE) or current period (K_TICK)
    int off;   // expected mole-dark cycles after the step, 0 = game ends
  } step_t;

  step_t steps[11];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic wait_mole_on(input string name);
    int w = 0;
    while (bus.mole == 4'd0 && w < 40) begin
      @(negedge clk1s);
      w++;
    end
    if (bus.mole == 4'd0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_mole_off(input string name);
    int w = 0;
    while (bus.mole != 4'd0 && w < 40) begin
      @(negedge clk1s);
      w++;
    end
    if (bus.mole != 4'd0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic start_game(input string name);
    int n = 0;
    bus.start = 1'b1;
    while (bus.mole == 4'd0 && n < 10) begin
      @(negedge clk1s);
      n++;
    end
    chk({name, "_mole_within_3"}, (n <= 3 && bus.mole != 4'd0) ? 1 : 0, 1);
    chk({name, "_lives"}, bus.lives, 3);
    chk({name, "_score"}, bus.score, 0);
    chk({name, "_level"}, bus.level, 0);
    chk({name, "_game_over"}, bus.game_over, 0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_mole;
    logic       saw_tick;
    int         cnt;
    int         old_lives;

    //             kind    score level lives on off
    steps[0]  = '{K_NONE, 0, 0, 2, 10, 11};
    steps[1]  = '{K_LIT,  1, 0, 2,  0, 11};
    steps[2]  = '{K_BOTH, 2, 1, 2,  0,  9};
    steps[3]  = '{K_TICK, 3, 1, 2,  8,  9};
    steps[4]  = '{K_LIT,  4, 2, 2,  0,  7};
    steps[5]  = '{K_NONE, 4, 2, 1,  6,  7};
    steps[6]  = '{K_LIT,  5, 2, 1,  0,  7};
    steps[7]  = '{K_LIT,  6, 3, 1,  0,  5};
    steps[8]  = '{K_LIT,  7, 3, 1,  0,  5};
    steps[9]  = '{K_LIT,  8, 4, 1,  0,  5};
    steps[10] = '{K_NONE, 8, 4, 0,  4,  0};

    bus.start = 1'b0;
    bus.btn   = 4'd0;

    // Reset and idle
    repeat (3) @(negedge clk1s);
    rst = 1'b0;
    saw_tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk1s);
      if (bus.tick) saw_tick = 1'b1;
      if (bus.mole != 4'd0 || bus.playing) cnt++;
    end
    chk("idle_mole_or_playing_cycles", cnt, 0);
    chk("idle_tick_seen", saw_tick, 0);
    chk("idle_lives", bus.lives, 0);
    chk("idle_score", bus.score, 0);
    chk("idle_level", bus.level, 0);
    chk("idle_game_over", bus.game_over, 0);

    // Game 1: table-driven sequence of windows
    start_game("g1_start");
    prev_mole = 4'd0;
    for (int i = 0; i < 11; i++) begin
      wait_mole_on($sformatf("s%0d_mole_on", i));
      chk($sformatf("s%0d_onehot", i), $countones(bus.mole), 1);
      chk($sformatf("s%0d_hole_changed", i), (bus.mole != prev_mole) ? 1 : 0, 1);
      chk($sformatf("s%0d_playing", i), bus.playing, 1);
      prev_mole = bus.mole;
      case (steps[i].kind)
        K_NONE: begin
          cnt = 0;
          while (bus.mole != 4'd0 && cnt < 40) begin
            cnt++;
            @(negedge clk1s);
          end
          chk($sformatf("s%0d_show_len", i), cnt, steps[i].on);
        end
        K_TICK: begin
          repeat (steps[i].on - 2) @(negedge clk1s);
          bus.btn = bus.mole;
          @(negedge clk1s);
          bus.btn = 4'd0;
          @(negedge clk1s);
          chk($sformatf("s%0d_tick_with_hit", i), bus.tick, 1);
          chk($sformatf("s%0d_mole_off", i), (bus.mole == 4'd0) ? 1 : 0, 1);
        end
        default: begin
          bus.btn = (steps[i].kind == K_BOTH) ? (bus.mole | rotl(bus.mole)) : bus.mole;
          @(negedge clk1s);
          bus.btn = 4'd0;
          wait_mole_off($sformatf("s%0d_mole_off", i));
        end
      endcase
      chk($sformatf("s%0d_score", i), bus.score, steps[i].score);
      chk($sformatf("s%0d_level", i), bus.level, steps[i].level);
      chk($sformatf("s%0d_lives", i), bus.lives, steps[i].lives);
      if (steps[i].off != 0) begin
        cnt = 0;
        while (bus.mole == 4'd0 && cnt < 40) begin
          cnt++;
          @(negedge clk1s);
        end
        chk($sformatf("s%0d_dark_len", i), cnt, steps[i].off);
      end
    end

    // Game over: everything frozen, no ticks
    chk("over_game_over", bus.game_over, 1);
    chk("over_playing", bus.playing, 0);
    saw_tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1s);
      if (bus.tick) saw_tick = 1'b1;
      if (bus.mole != 4'd0) cnt++;
    end
    chk("over_mole_cycles", cnt, 0);
    chk("over_tick_seen", saw_tick, 0);
    chk("over_score_held", bus.score, 8);
    chk("over_level_held", bus.level, 4);

    // Game 2: restart from OVER, wrong-hole miss timing, then async reset mid-SHOW
    start_game("g2_start");
    old_lives = bus.lives;
    bus.btn = rotl(bus.mole);
    @(negedge clk1s);
    bus.btn = 4'd0;
    chk("wrong_lives_not_yet", bus.lives, old_lives);
    @(negedge clk1s);
    chk("wrong_lives_dec", bus.lives, old_lives - 1);
    chk("wrong_mole_off", bus.mole, 0);
    chk("wrong_score", bus.score, 0);
    wait_mole_on("g2_second_window");
    chk("g2_second_onehot", $countones(bus.mole), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_mole", bus.mole, 0);
    chk("rst_async_lives", bus.lives, 0);
    chk("rst_async_playing", bus.playing, 0);
    chk("rst_async_game_over", bus.game_over, 0);
    chk("rst_async_score", bus.score, 0);
    chk("rst_async_tick", bus.tick, 0);
    @(negedge clk1s);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk1s);
      if (bus.mole != 4'd0 || bus.playing || bus.tick) cnt++;
    end
    chk("post_rst_idle_cycles", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
